uart_rx_frontend: RTL and testbench

//  Serial command receiver directly upstream of the tt_um_gmejiamtz core.
//  - Samples an asynchronous RX pin taken from ui_in.
//  - Deframes 8N1 UART characters, LSB first.
//  - Presents each received byte to the core on a valid/ready handshake through a one-entry holding register.
//  - Flags framing errors and overruns.

---
 rtl/uart_rx_frontend.sv | 165 ++++++++++++++++
 tb/tb_uart_rx_frontend.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: 8N1 UART receiver with a one-entry
// valid/ready holding register, framing-error and overrun pulses.
module uart_rx_frontend #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic                 rx_meta;
  logic                 rx_s;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] sr;
  logic                 cnt_zero;
  logic                 byte_done;
  logic                 fe_hit;
  logic                 bit_take;
  logic                 fe_q;
  logic                 ov_q;

  assign cnt_zero = (cnt == '0);

  // Two-flop synchroniser for the asynchronous RX pin, idle high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  // State register; busy tracks the state it is registered with.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy_o <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_o <= (state_nxt != IDLE);
    end
  end

  // Next-state logic; dropping ena aborts any frame in flight.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (!rx_s) state_nxt = START;
      START:     if (cnt_zero) state_nxt = rx_s ? IDLE : DATA;
      DATA:      if (cnt_zero && idx == LAST) state_nxt = STOP;
      STOP:      if (cnt_zero) state_nxt = rx_s ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rx_s) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    if (!ena) state_nxt = IDLE;
  end

  // Sample strobes decoded from the current state.
  always_comb begin
    byte_done = 1'b0;
    fe_hit    = 1'b0;
    bit_take  = 1'b0;
    if (ena && cnt_zero) begin
      byte_done = (state == STOP) && rx_s;
      fe_hit    = (state == STOP) && !rx_s;
      bit_take  = (state == DATA);
    end
  end

  // Bit timer, bit index and shift register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
      sr  <= '0;
    end else if (!ena) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!rx_s) cnt <= HALF;
        end
        START: begin
          if (!cnt_zero) begin
            cnt <= cnt - CW'(1);
          end else if (!rx_s) begin
            cnt <= FULL;
            idx <= '0;
          end
        end
        DATA: begin
          if (!cnt_zero) begin
            cnt <= cnt - CW'(1);
          end else begin
            sr[idx] <= rx_s;
            cnt     <= FULL;
            idx     <= idx + IW'(1);
          end
        end
        STOP: begin
          if (!cnt_zero) cnt <= cnt - CW'(1);
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

  // One-entry holding register with valid/ready handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_o  <= '0;
      valid_o <= 1'b0;
    end else if (byte_done && (!valid_o || ready_i)) begin
      data_o  <= sr;
      valid_o <= 1'b1;
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end
  end

  // Error pulses, registered to line up with valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fe_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      fe_q <= fe_hit;
      ov_q <= byte_done && valid_o && !ready_i;
    end
  end

  assign frame_err_o = fe_q && ena;
  assign overrun_o   = ov_q && ena;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb_uart_rx_frontend: directed frames against uart_rx_frontend,
// monitor collects transfers and error pulses.
module tb_uart_rx_frontend;

  localparam int CPB = 217;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       rx_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int val_cyc = 0;
  logic [7:0] got[$];

  uart_rx_frontend #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .rx_i(rx_i),
    .data_o(data_o),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .frame_err_o(frame_err_o),
    .overrun_o(overrun_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Monitor on the falling edge: inputs change just after posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_o && ready_i) got.push_back(data_o);
      if (valid_o) val_cyc++;
      if (frame_err_o) fe_cnt++;
      if (overrun_o) ov_cnt++;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear();
    fe_cnt  = 0;
    ov_cnt  = 0;
    val_cyc = 0;
    got.delete();
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    rx_i = 1'b0;
    clks(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      clks(CPB);
    end
    rx_i = stop;
    clks(CPB);
  endtask

  function automatic logic [31:0] at(input int i);
    if (got.size() > i) return 32'(got[i]);
    return 32'hDEAD;
  endfunction

  initial begin
    rst_n   = 1'b0;
    ena     = 1'b1;
    rx_i    = 1'b1;
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    clks(3);
    check("rst_valid", 32'(valid_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_data", 32'(data_o), 0);
    check("rst_fe", 32'(frame_err_o), 0);
    check("rst_ov", 32'(overrun_o), 0);
    rst_n = 1'b1;
    clks(5);

    clear();
    send(8'hA5, 1'b1);
    clks(300);
    check("t1_count", got.size(), 1);
    check("t1_data", at(0), 32'hA5);
    check("t1_vcyc", val_cyc, 1);
    check("t1_fe", fe_cnt, 0);
    check("t1_ov", ov_cnt, 0);

    clear();
    ready_i = 1'b0;
    send(8'h3C, 1'b1);
    send(8'hC3, 1'b1);
    clks(300);
    check("t2_hold", 32'(data_o), 32'h3C);
    check("t2_valid", 32'(valid_o), 1);
    check("t2_ov", ov_cnt, 1);
    ready_i = 1'b1;
    clks(2);
    check("t2_drop", 32'(valid_o), 0);
    check("t2_xfer", at(0), 32'h3C);
    check("t2_count", got.size(), 1);

    clear();
    rx_i = 1'b0;
    clks(20);
    check("t3_busy", 32'(busy_o), 1);
    clks(20);
    rx_i = 1'b1;
    clks(120);
    check("t3_idle", 32'(busy_o), 0);
    check("t3_count", got.size(), 0);
    check("t3_fe", fe_cnt, 0);

    clear();
    send(8'h55, 1'b0);
    clks(1000);
    check("t4_hold", 32'(busy_o), 1);
    rx_i = 1'b1;
    clks(20);
    check("t4_idle", 32'(busy_o), 0);
    send(8'h81, 1'b1);
    clks(300);
    check("t4_fe", fe_cnt, 1);
    check("t4_count", got.size(), 1);
    check("t4_data", at(0), 32'h81);

    clear();
    send(8'h01, 1'b1);
    send(8'h02, 1'b1);
    clks(300);
    check("t5_count", got.size(), 2);
    check("t5_d0", at(0), 32'h01);
    check("t5_d1", at(1), 32'h02);
    check("t5_ov", ov_cnt, 0);

    clear();
    rx_i = 1'b0;
    clks(CPB);
    rx_i = 1'b1;
    clks(3 * CPB);
    check("t6_busy", 32'(busy_o), 1);
    ena = 1'b0;
    clks(1);
    check("t6_abort", 32'(busy_o), 0);
    clks(6 * CPB);
    ena = 1'b1;
    clks(50);
    send(8'h7E, 1'b1);
    clks(300);
    check("t6_count", got.size(), 1);
    check("t6_xfer", at(0), 32'h7E);
    check("t6_data", 32'(data_o), 32'h7E);
    check("t6_fe", fe_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
